// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the two-port data-memory controller:
//   - access size encodings (SZ_BYTE, SZ_HALF, SZ_WORD; 2'b11 behaves as word)
//   - controller state enum
//   - load extension and sub-word-store helpers
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RMW_RD = 2'd2,
        RMW_WR = 2'd3
    } stateType;

    // Extend the low byte/half of a fetched word; word (and 2'b11) pass through.
    function automatic logic [31:0] extendLoad(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic        isUnsigned);
        case (size)
            SZ_BYTE: extendLoad = {{24{~isUnsigned & word[7]}}, word[7:0]};
            SZ_HALF: extendLoad = {{16{~isUnsigned & word[15]}}, word[15:0]};
            default: extendLoad = word;
        endcase
    endfunction

    function automatic logic isSubWord(input logic [1:0] size);
        isSubWord = (size == SZ_BYTE) || (size == SZ_HALF);
    endfunction

endpackage

// File: rtl/dmem_ctrl_rr_arb2.sv
// rr_arb2
// Two-requester round-robin arbiter. A lone requester always wins; on a tie
// the requester that was not served last wins. The last-served pointer
// resets to 1 so requester 0 wins the first tie.
// Ports:
//   clk, rst      clock (posedge), asynchronous active-high reset
//   req0, req1    requests (already qualified by the caller)
//   gnt0, gnt1    combinational grants, at most one high
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic lastServed;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            gnt0 = lastServed;
            gnt1 = ~lastServed;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastServed <= 1'b1;
        end else if (gnt0) begin
            lastServed <= 1'b0;
        end else if (gnt1) begin
            lastServed <= 1'b1;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl
// Shares one byte-addressed data memory between the core load/store path
// (port 0) and the debug/loader path (port 1). Handles byte/half/word
// accesses, load extension, and read-modify-write for sub-word stores since
// the memory only accepts full 32-bit little-endian writes (committed on the
// negedge of the write cycle).
// Ports (x = 0,1):
//   mx_req_i/we_i/size_i/unsigned_i/addr_i/wdata_i   request
//   mx_gnt_o                                          combinational grant (IDLE only)
//   mx_rsp_valid_o/rsp_err_o/rdata_o                  registered one-cycle response
//   mem_addr_o/wdata_o/ren_o/wen_o, mem_rdata_i       memory side
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [1:0]  m0_size_i,
    input  logic        m0_unsigned_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rsp_valid_o,
    output logic        m0_rsp_err_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [1:0]  m1_size_i,
    input  logic        m1_unsigned_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rsp_valid_o,
    output logic        m1_rsp_err_o,
    output logic [31:0] m1_rdata_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_ren_o,
    output logic        mem_wen_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

    stateType    state, nextState;
    logic        isIdle, granted;
    logic        selWe, selUns, selErr;
    logic [1:0]  selSize;
    logic [31:0] selAddr, selWdata;
    logic        latPort, latWe, latUns, latErr;
    logic [1:0]  latSize;
    logic [31:0] latAddr, latWdata, merge;
    logic        done;
    logic [31:0] doneRdata;

    assign isIdle = (state == IDLE);

    rr_arb2 uArb (
        .clk  (clk_i),
        .rst  (rst_i),
        .req0 (m0_req_i & isIdle),
        .req1 (m1_req_i & isIdle),
        .gnt0 (m0_gnt_o),
        .gnt1 (m1_gnt_o)
    );

    assign granted  = m0_gnt_o | m1_gnt_o;
    assign selWe    = m1_gnt_o ? m1_we_i       : m0_we_i;
    assign selSize  = m1_gnt_o ? m1_size_i     : m0_size_i;
    assign selUns   = m1_gnt_o ? m1_unsigned_i : m0_unsigned_i;
    assign selAddr  = m1_gnt_o ? m1_addr_i     : m0_addr_i;
    assign selWdata = m1_gnt_o ? m1_wdata_i    : m0_wdata_i;
    assign selErr   = selAddr > LAST_ADDR;

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (granted) begin
                    nextState = (selWe && isSubWord(selSize) && !selErr) ? RMW_RD : ACCESS;
                end
            end
            ACCESS: nextState = IDLE;
            RMW_RD: nextState = RMW_WR;
            RMW_WR: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Memory side is purely combinational from state and latched request so
    // that a reset in a write state removes mem_wen_o before the negedge.
    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_ren_o   = 1'b0;
        mem_wen_o   = 1'b0;
        if (!isIdle) begin
            mem_addr_o = latAddr;
        end
        case (state)
            ACCESS: begin
                // Only word stores reach ACCESS without an error.
                if (!latErr) begin
                    mem_ren_o = ~latWe;
                    mem_wen_o = latWe;
                    if (latWe) begin
                        mem_wdata_o = latWdata;
                    end
                end
            end
            RMW_RD: mem_ren_o = 1'b1;
            RMW_WR: begin
                mem_wen_o   = 1'b1;
                mem_wdata_o = (latSize == SZ_BYTE) ? {merge[31:8], latWdata[7:0]}
                                                   : {merge[31:16], latWdata[15:0]};
            end
            default: ;
        endcase
    end

    assign done      = (state == ACCESS) || (state == RMW_WR);
    assign doneRdata = (state == ACCESS && !latWe && !latErr)
                       ? extendLoad(mem_rdata_i, latSize, latUns) : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            latPort        <= 1'b0;
            latWe          <= 1'b0;
            latSize        <= '0;
            latUns         <= 1'b0;
            latAddr        <= '0;
            latWdata       <= '0;
            latErr         <= 1'b0;
            merge          <= '0;
            m0_rsp_valid_o <= 1'b0;
            m0_rsp_err_o   <= 1'b0;
            m0_rdata_o     <= '0;
            m1_rsp_valid_o <= 1'b0;
            m1_rsp_err_o   <= 1'b0;
            m1_rdata_o     <= '0;
        end else begin
            state <= nextState;
            if (granted) begin
                latPort  <= m1_gnt_o;
                latWe    <= selWe;
                latSize  <= selSize;
                latUns   <= selUns;
                latAddr  <= selAddr;
                latWdata <= selWdata;
                latErr   <= selErr;
            end
            if (state == RMW_RD) begin
                merge <= mem_rdata_i;
            end
            m0_rsp_valid_o <= done & ~latPort;
            m0_rsp_err_o   <= done & ~latPort & latErr;
            m0_rdata_o     <= (done && !latPort) ? doneRdata : '0;
            m1_rsp_valid_o <= done & latPort;
            m1_rsp_err_o   <= done & latPort & latErr;
            m1_rdata_o     <= (done && latPort) ? doneRdata : '0;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0Req = 0, m0We = 0, m0Uns = 0, m1Req = 0, m1We = 0, m1Uns = 0;
    logic [1:0]  m0Size = 0, m1Size = 0;
    logic [31:0] m0Addr = 0, m0Wdata = 0, m1Addr = 0, m1Wdata = 0;
    logic        m0Gnt, m0RspValid, m0RspErr, m1Gnt, m1RspValid, m1RspErr;
    logic [31:0] m0Rdata, m1Rdata;
    logic [31:0] memAddr, memWdata, memRdata;
    logic        memRen, memWen;

    bit [7:0] tbMem  [MEM_BYTES];
    bit [7:0] refMem [MEM_BYTES];
    bit       refLast = 1'b1;
    int       checks = 0;
    int       failures = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0Req), .m0_we_i(m0We), .m0_size_i(m0Size), .m0_unsigned_i(m0Uns),
        .m0_addr_i(m0Addr), .m0_wdata_i(m0Wdata), .m0_gnt_o(m0Gnt),
        .m0_rsp_valid_o(m0RspValid), .m0_rsp_err_o(m0RspErr), .m0_rdata_o(m0Rdata),
        .m1_req_i(m1Req), .m1_we_i(m1We), .m1_size_i(m1Size), .m1_unsigned_i(m1Uns),
        .m1_addr_i(m1Addr), .m1_wdata_i(m1Wdata), .m1_gnt_o(m1Gnt),
        .m1_rsp_valid_o(m1RspValid), .m1_rsp_err_o(m1RspErr), .m1_rdata_o(m1Rdata),
        .mem_addr_o(memAddr), .mem_wdata_o(memWdata), .mem_ren_o(memRen),
        .mem_wen_o(memWen), .mem_rdata_i(memRdata)
    );

    // Memory attached to the DUT: combinational read, write on negedge.
    always @(negedge clk) begin
        if (memWen && memAddr <= 32'(MEM_BYTES - 4)) begin
            for (int i = 0; i < 4; i++) tbMem[int'(memAddr) + i] <= memWdata[8*i +: 8];
        end
    end

    always_comb begin
        memRdata = '0;
        if (memAddr <= 32'(MEM_BYTES - 4)) begin
            for (int i = 0; i < 4; i++) memRdata[8*i +: 8] = tbMem[int'(memAddr) + i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] refWord(input int a);
        return {refMem[a+3], refMem[a+2], refMem[a+1], refMem[a]};
    endfunction

    // Reference load: plain arithmetic on the byte array.
    function automatic logic [31:0] refLoad(input int a, input logic [1:0] size, input logic uns);
        int v;
        if (size == 2'd0) begin
            v = int'(refMem[a]);
            if (!uns && v >= 128) v = v - 256;
        end else if (size == 2'd1) begin
            v = int'(refMem[a]) + 256 * int'(refMem[a+1]);
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            return refWord(a);
        end
        return 32'(v);
    endfunction

    function automatic void refStore(input int a, input logic [1:0] size, input logic [31:0] d);
        int n;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) refMem[a + i] = d[8*i +: 8];
    endfunction

    task automatic drive(input int port, input logic req, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            m0Req = req; m0We = we; m0Size = size; m0Uns = uns; m0Addr = addr; m0Wdata = wdata;
        end else begin
            m1Req = req; m1We = we; m1Size = size; m1Uns = uns; m1Addr = addr; m1Wdata = wdata;
        end
    endtask

    // One transaction from a lone requester, starting from IDLE.
    task automatic doTxn(input int port, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        logic        err, sawOther, gotErr;
        int          expLat, gotLat, wenCyc;
        logic [31:0] expRdata, expWword, gotWword, gotRdata;
        err      = addr > 32'(MEM_BYTES - 4);
        expLat   = (we && size < 2'd2 && !err) ? 3 : 2;
        expRdata = (!we && !err) ? refLoad(int'(addr), size, uns) : 32'h0;
        expWword = 32'h0;
        if (we && !err) begin
            refStore(int'(addr), size, wdata);
            expWword = refWord(int'(addr));
        end
        @(negedge clk);
        drive(port, 1'b1, we, size, uns, addr, wdata);
        #1;
        check("gnt_own", 32'(port == 0 ? m0Gnt : m1Gnt), 32'd1);
        check("gnt_other", 32'(port == 0 ? m1Gnt : m0Gnt), 32'd0);
        refLast = (port != 0);
        @(negedge clk);
        drive(port, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        gotLat = 0; wenCyc = 0; gotWword = 0; gotRdata = 0; gotErr = 0; sawOther = 0;
        for (int c = 1; c <= 6 && gotLat == 0; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            if (memWen) begin
                wenCyc   = c;
                gotWword = memWdata;
            end
            if (port == 0 ? m1RspValid : m0RspValid) sawOther = 1'b1;
            if (port == 0 ? m0RspValid : m1RspValid) begin
                gotLat   = c;
                gotRdata = (port == 0) ? m0Rdata : m1Rdata;
                gotErr   = (port == 0) ? m0RspErr : m1RspErr;
            end
        end
        check("rsp_latency", 32'(gotLat), 32'(expLat));
        check("rsp_rdata", gotRdata, expRdata);
        check("rsp_err", 32'(gotErr), 32'(err));
        check("rsp_other_port", 32'(sawOther), 32'd0);
        check("wen_cycle", 32'(wenCyc), (we && !err) ? 32'(expLat - 1) : 32'd0);
        if (we && !err) check("wen_wdata", gotWword, expWword);
    endtask

    initial begin
        int w;
        int expPortAt[12];
        logic sawRsp;
        int  got;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_rsp0", 32'(m0RspValid), 32'd0);
        check("rst_rsp1", 32'(m1RspValid), 32'd0);
        check("rst_wen", 32'(memWen), 32'd0);
        check("rst_ren", 32'(memRen), 32'd0);
        check("rst_rdata0", m0Rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Word store then load
        doTxn(0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF);
        doTxn(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        // Sub-word RMW and extension
        doTxn(0, 1'b1, SZ_BYTE, 1'b0, 32'h10, 32'h000000A5);
        doTxn(0, 1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0);
        doTxn(0, 1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0);
        check("model_byte_signed", refLoad(32'h10, SZ_BYTE, 1'b0), 32'hFFFFFFA5);

        // Round robin with both ports requesting every cycle
        doTxn(1, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h11223344);
        doTxn(1, 1'b1, SZ_WORD, 1'b0, 32'h40, 32'h55667788);
        doTxn(1, 1'b1, SZ_BYTE, 1'b0, 32'h41, 32'h000000F3);
        foreach (expPortAt[i]) expPortAt[i] = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin
                drive(0, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0);
                drive(1, 1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h41, 32'h0);
            end
            if (c == 8) begin
                m0Req = 1'b0;
                m1Req = 1'b0;
            end
            #1;
            if (c < 8 && c % 2 == 0) begin
                w = refLast ? 0 : 1;
                check("rr_gnt0", 32'(m0Gnt), 32'(w == 0));
                check("rr_gnt1", 32'(m1Gnt), 32'(w == 1));
                refLast = (w == 1);
                expPortAt[c + 2] = w;
            end else begin
                check("rr_no_gnt", 32'({m0Gnt, m1Gnt}), 32'd0);
            end
            check("rr_rsp0", 32'(m0RspValid), 32'(expPortAt[c] == 0));
            check("rr_rsp1", 32'(m1RspValid), 32'(expPortAt[c] == 1));
            if (expPortAt[c] == 0) check("rr_rdata0", m0Rdata, refLoad(32'h20, SZ_WORD, 1'b0));
            if (expPortAt[c] == 1) check("rr_rdata1", m1Rdata, refLoad(32'h41, SZ_BYTE, 1'b0));
        end

        // Range boundary
        doTxn(1, 1'b1, SZ_WORD, 1'b0, 32'(MEM_BYTES - 3), 32'hCAFEF00D);
        doTxn(1, 1'b0, SZ_WORD, 1'b0, 32'(MEM_BYTES - 3), 32'h0);
        doTxn(1, 1'b1, SZ_BYTE, 1'b0, 32'hFFFF_FFF0, 32'h12);
        doTxn(1, 1'b1, SZ_WORD, 1'b0, 32'(MEM_BYTES - 4), 32'hA1B2C3D4);
        doTxn(0, 1'b0, SZ_WORD, 1'b0, 32'(MEM_BYTES - 4), 32'h0);

        // Reset during RMW_WR of a half store
        doTxn(0, 1'b1, SZ_WORD, 1'b0, 32'h30, 32'h87654321);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, SZ_HALF, 1'b0, 32'h30, 32'h0000ABCD);
        #1;
        check("rmw_gnt", 32'(m0Gnt), 32'd1);
        @(negedge clk);
        m0Req = 1'b0;
        @(posedge clk);
        #1;
        check("rmw_wr_wen", 32'(memWen), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_drops_wen", 32'(memWen), 32'd0);
        sawRsp = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            if (m0RspValid || m1RspValid) sawRsp = 1'b1;
        end
        rst = 1'b0;
        refLast = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (m0RspValid || m1RspValid) sawRsp = 1'b1;
        end
        check("rst_no_rsp", 32'(sawRsp), 32'd0);
        // Tie after reset goes to port 0
        @(negedge clk);
        drive(0, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0);
        drive(1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        #1;
        check("tie_gnt0", 32'(m0Gnt), 32'd1);
        check("tie_gnt1", 32'(m1Gnt), 32'd0);
        refLast = 1'b0;
        @(negedge clk);
        m0Req = 1'b0;
        m1Req = 1'b0;
        got = 0;
        for (int c = 1; c <= 6 && got == 0; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            if (m0RspValid) begin
                got = c;
                check("rst_mem_unchanged", m0Rdata, refWord(32'h30));
            end
        end
        check("tie_rsp_latency", 32'(got), 32'd2);
        doTxn(1, 1'b0, SZ_HALF, 1'b1, 32'h30, 32'h0);
        doTxn(0, 1'b0, SZ_BYTE, 1'b1, 32'h33, 32'h0);

        // Randomized transactions against the byte-array model
        for (int n = 0; n < 80; n++) begin
            int          port;
            logic        we, uns;
            logic [1:0]  size;
            logic [31:0] addr;
            port = int'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       addr = 32'(MEM_BYTES - 4) + 32'($urandom_range(1, 3000));
                1:       addr = 32'(MEM_BYTES - 4) - 32'($urandom_range(0, 3));
                default: addr = 32'($urandom_range(0, 63));
            endcase
            doTxn(port, we, size, uns, addr, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Two-port controller sharing the single byte-addressed data memory between the core load/store path (port 0) and the debug/program-loader path (port 1). Round-robin arbitration, a request/grant/response handshake per port, byte/halfword/word accesses with load sign/zero extension, and read-modify-write sequencing for sub-word stores. The memory itself only takes full 32-bit little-endian writes. Sits between the MEM stage / loader and the data memory; all controller state updates on posedge, and the memory commits writes on the following negedge.

## Interface
Parameters:
- MEM_BYTES, 1024, memory size in bytes; legal access iff addr ≤ MEM_BYTES-4

Ports (x = 0, 1):
- clk_i  in  1  clock, posedge
- rst_i  in  1  asynchronous, active-high reset
- mx_req_i  in  1  request valid; hold until granted
- mx_we_i  in  1  1 = store, 0 = load
- mx_size_i  in  2  00 byte, 01 half, 10 word (11 treated as word)
- mx_unsigned_i  in  1  load zero-extend (1) / sign-extend (0)
- mx_addr_i  in  32  byte address, alignment not required
- mx_wdata_i  in  32  store data, low bytes used for sub-word
- mx_gnt_o  out  1  request accepted this cycle (combinational)
- mx_rsp_valid_o  out  1  one-cycle completion pulse, loads and stores
- mx_rsp_err_o  out  1  address out of range, valid with rsp
- mx_rdata_o  out  32  extended load data, valid with rsp; 0 for stores and errors
- mem_addr_o  out  32  to memory address
- mem_wdata_o  out  32  to memory write data
- mem_ren_o  out  1  memory read enable
- mem_wen_o  out  1  memory write enable
- mem_rdata_i  in  32  combinational memory read data

## Operation
- States: IDLE, ACCESS, RMW_RD, RMW_WR.
- Grants are issued only in IDLE. On grant, the request is latched: port id, we, size, unsigned, addr, wdata, err = (addr > MEM_BYTES-4).
- Arbitration: round-robin with a last-served pointer. The pointer resets to 1, so port 0 wins the first tie. With simultaneous requests, the port not last served wins. A lone requester always wins.
- IDLE → RMW_RD if the access is a sub-word store and !err; otherwise IDLE → ACCESS.
- ACCESS: mem_addr_o = latched addr.
  - Load: mem_ren_o = 1; mem_rdata_i is captured.
  - Store (word only): mem_wen_o = 1, mem_wdata_o = wdata.
  - If err: both enables are 0.
  - Next state: IDLE.
- RMW_RD: mem_ren_o = 1; capture mem_rdata_i into the merge register. Next state: RMW_WR.
- RMW_WR: mem_wen_o = 1.
  - Byte store: mem_wdata_o = {merge[31:8], wdata[7:0]}.
  - Half store: mem_wdata_o = {merge[31:16], wdata[15:0]}.
  - Next state: IDLE.
- Load extension from the captured word:
  - Byte: bit 7 sign / zero fill.
  - Half: bit 15 sign / zero fill.
  - Word: unchanged.
- The response is registered: rsp_valid is raised for the latched port on the cycle after ACCESS or RMW_WR. The other port's outputs stay 0.
- Memory outputs are combinational from state plus latched fields; both enables are 0 in IDLE, and mem_wdata_o is 0 when mem_wen_o = 0.

## Timing
- Reset (async, immediate):
  - State returns to IDLE.
  - Pointer is set to 1.
  - All rsp_*, rdata, mem_* outputs and latched fields go to 0.
  - A reset during ACCESS or RMW_WR drops mem_wen_o before the negedge, so no partial write occurs.
  - An in-flight request is lost with no response.
- Latency from grant (cycle 0):
  - Load, word store, or error: ACCESS at cycle 1, rsp at cycle 2.
  - Sub-word store: RMW_RD at 1, RMW_WR at 2, rsp at 3.
- A new grant may coincide with the previous rsp cycle (state is IDLE). Peak throughput: one access per 2 cycles.
- mx_gnt_o is low in every non-IDLE state. A requester holding req sees gnt when it wins in IDLE.
- Back-to-back port-0 stores followed by a load of the same address: the load sees the stored data, because memory writes at the negedge of the write cycle.

## Structure
- dmem_pkg holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD)
  - the state enum
  - the load extension function
- One sub-module, rr_arb2: 2-request round-robin arbiter with pointer update on grant; its inputs are qualified by state == IDLE.

## Test plan
- Word store then load: m0 store addr 0x10, data 0xDEADBEEF. Then m0 word load 0x10 → rsp at +2, rdata 0xDEADBEEF, err 0.
- Sub-word RMW: m0 byte store 0xA5 to 0x10 → mem_wen_o in cycle 2 with wdata 0xDEADBEA5. Then a signed byte load of 0x10 → 0xFFFFFFA5, and an unsigned half load of 0x10 → 0x0000BEA5.
- Round-robin: m0 and m1 both request loads at the same time, every cycle. Grants are m0 first, then alternate m1, m0, m1; each rsp pulse goes only to the granted port.
- Range error: m1 word store to MEM_BYTES-3 → mem_wen_o never 1; rsp at +2 with err = 1, rdata 0. Addr MEM_BYTES-4 completes normally.
- Reset mid-RMW: assert rst_i during RMW_WR of a half store → mem_wen_o drops immediately; memory unchanged; no rsp. After release, state is IDLE, both gnt ports work, and a tie is won by m0.
